add_share_arb: RTL

ADD_SHARE_ARB -- requirements
Module: add_share_arb

---
 rtl/dlx_alu_pkg.sv | 18 +
 rtl/add_core32.sv | 50 +++++
 rtl/add_share_arb.sv | 125 ++++++++++++
 3 files changed

// File: rtl/dlx_alu_pkg.sv
// Shared ALU types: word width, requester id and the result-FIFO entry layout.
package dlx_alu_pkg;

   localparam int unsigned WORD_W = 32;

   typedef logic req_id_t;

   typedef struct packed {
      logic [WORD_W-1:0] sum;
      logic              cout;
      req_id_t           id;
   } result_t;

   function automatic logic [1:0] id_to_onehot(input req_id_t id);
      return id ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/add_core32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups chained by group generate/propagate.
module add_core32
   import dlx_alu_pkg::*;
(
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   input  logic              cin,
   output logic [WORD_W-1:0] sum,
   output logic              cout
);

   localparam int unsigned GRP_W = 4;
   localparam int unsigned NGRP  = WORD_W / GRP_W;

   always_comb begin : cla
      logic [WORD_W-1:0] g;
      logic [WORD_W-1:0] p;
      logic [WORD_W-1:0] c;
      logic [NGRP:0]     gc;
      logic              grp_g;
      logic              grp_p;
      g     = a & b;
      p     = a ^ b;
      c     = '0;
      gc    = '0;
      grp_g = 1'b0;
      grp_p = 1'b0;
      gc[0] = cin;
      for (int k = 0; k < NGRP; k++) begin
         c[GRP_W*k]   = gc[k];
         c[GRP_W*k+1] = g[GRP_W*k] | (p[GRP_W*k] & gc[k]);
         c[GRP_W*k+2] = g[GRP_W*k+1]
                      | (p[GRP_W*k+1] & g[GRP_W*k])
                      | (p[GRP_W*k+1] & p[GRP_W*k] & gc[k]);
         c[GRP_W*k+3] = g[GRP_W*k+2]
                      | (p[GRP_W*k+2] & g[GRP_W*k+1])
                      | (p[GRP_W*k+2] & p[GRP_W*k+1] & g[GRP_W*k])
                      | (p[GRP_W*k+2] & p[GRP_W*k+1] & p[GRP_W*k] & gc[k]);
         grp_g = g[GRP_W*k+3]
               | (p[GRP_W*k+3] & g[GRP_W*k+2])
               | (p[GRP_W*k+3] & p[GRP_W*k+2] & g[GRP_W*k+1])
               | (p[GRP_W*k+3] & p[GRP_W*k+2] & p[GRP_W*k+1] & g[GRP_W*k]);
         grp_p = &p[GRP_W*k +: GRP_W];
         gc[k+1] = grp_g | (grp_p & gc[k]);
      end
      sum  = p ^ c;
      cout = gc[NGRP];
   end

endmodule

// File: rtl/add_share_arb.sv
// Two requesters share one CLA adder through a round-robin arbiter; results queue in an in-order FIFO.
// Define ADD_SHARE_ARB_SUB_EN to honour reqN_sub (A-B); otherwise every operation is an add.
module add_share_arb
   import dlx_alu_pkg::*;
#(
   parameter int unsigned DEPTH = 2
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [WORD_W-1:0] req0_a,
   input  logic [WORD_W-1:0] req0_b,
   input  logic [WORD_W-1:0] req1_a,
   input  logic [WORD_W-1:0] req1_b,
   input  logic              req0_sub,
   input  logic              req1_sub,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [WORD_W-1:0] rsp_sum,
   output logic              rsp_cout,
   output logic              rsp_id
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   result_t           mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   req_id_t           prio;
   req_id_t           winner;
   logic              full;
   logic              pop;
   logic              grant;
   logic [WORD_W-1:0] op_a;
   logic [WORD_W-1:0] op_b;
   logic [WORD_W-1:0] op_b_eff;
   logic              op_sub;
   logic [WORD_W-1:0] add_sum;
   logic              add_cout;
   result_t           wr_entry;
   result_t           head;

   assign full      = (count == CNT_W'(DEPTH));
   assign rsp_valid = (count != '0);
   assign pop       = rsp_valid & rsp_ready;

   // Contention goes to the priority pointer; a lone requester always wins.
   always_comb begin
      winner = 1'b0;
      if (req_valid == 2'b11) begin
         winner = prio;
      end else if (req_valid[1]) begin
         winner = 1'b1;
      end
   end

   // A grant needs room, which a same-cycle pop provides even when full.
   assign grant     = rst_n & (|req_valid) & (~full | pop);
   assign req_ready = grant ? id_to_onehot(winner) : 2'b00;

   always_comb begin
      op_a   = winner ? req1_a : req0_a;
      op_b   = winner ? req1_b : req0_b;
`ifdef ADD_SHARE_ARB_SUB_EN
      op_sub = winner ? req1_sub : req0_sub;
`else
      op_sub = 1'b0;
`endif
      op_b_eff = op_sub ? ~op_b : op_b;
   end

`ifndef ADD_SHARE_ARB_SUB_EN
   logic unused_sub;
   assign unused_sub = req0_sub ^ req1_sub;
`endif

   add_core32 u_add (
      .a    (op_a),
      .b    (op_b_eff),
      .cin  (op_sub),
      .sum  (add_sum),
      .cout (add_cout)
   );

   assign wr_entry = '{sum: add_sum, cout: add_cout, id: winner};

   // Pointers, occupancy and arbitration pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         prio   <= 1'b0;
      end else begin
         if (grant) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            prio   <= ~winner;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({grant, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: contents are only visible while occupancy is non-zero.
   always_ff @(posedge clk) begin
      if (grant) begin
         mem[wr_ptr] <= wr_entry;
      end
   end

   assign head     = mem[rd_ptr];
   assign rsp_sum  = rsp_valid ? head.sum  : '0;
   assign rsp_cout = rsp_valid ? head.cout : 1'b0;
   assign rsp_id   = rsp_valid ? head.id   : 1'b0;

endmodule
